// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Shared constants, state encoding and operand-sign helpers for
//               the iterative RV32M multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int MDU_ITER = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_cond_neg.sv
// ============================================================================
// Module      : mdu_cond_neg
// Description : Combinational conditional two's-complement negate.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_cond_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_dout
);

    assign o_dout = i_neg ? (~i_din + WIDTH'(1)) : i_din;

endmodule

`default_nettype wire

// File: rtl/mdu_seq_ctrl.sv
// ============================================================================
// Module      : mdu_seq_ctrl
// Description : Iterative RV32M shift-add multiply / restoring divide beside
//               the EX-stage ALU. Optional macro MDU_MUL_EARLY_OUT_EN lets
//               multiplies finish once the remaining multiplier bits are zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq_ctrl
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_ITER
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int c_cnt_w = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(XLEN - 1);

    mdu_state_e            r_state, w_next;
    logic [2:0]            r_f3;
    logic                  r_sign_a, r_sign_b;
    logic [XLEN-1:0]       r_opnd, r_result;
    logic [2*XLEN-1:0]     r_acc;
    logic [c_cnt_w-1:0]    r_cnt;

    logic                  w_a_neg, w_b_neg, w_is_div, w_b_zero, w_ovf, w_special;
    logic [XLEN-1:0]       w_abs_a, w_abs_b, w_special_val;
    logic [XLEN:0]         w_add_a, w_add_b, w_sum;
    logic [2*XLEN-1:0]     w_acc_step, w_acc_calc;
    logic                  w_early;
    logic [XLEN-1:0]       w_lo, w_hi, w_fix_in, w_fix_out, w_fix_val;
    logic                  w_lo_zero, w_fix_neg, w_fix_ones;

    assign w_a_neg  = a_is_signed(funct3) & op_a[XLEN-1];
    assign w_b_neg  = b_is_signed(funct3) & op_b[XLEN-1];
    assign w_is_div = funct3[2];
    assign w_b_zero = (op_b == '0);
    assign w_ovf    = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                      (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    assign w_special = w_is_div & (w_b_zero | w_ovf);

    // funct3[1] separates REM/REMU from DIV/DIVU within the divide group
    always_comb begin
        w_special_val = '0;
        if (w_b_zero) w_special_val = funct3[1] ? op_a : '1;
        else          w_special_val = funct3[1] ? '0 : op_a;
    end

    mdu_cond_neg #(.WIDTH(XLEN)) u_abs_a (.i_din(op_a), .i_neg(w_a_neg), .o_dout(w_abs_a));
    mdu_cond_neg #(.WIDTH(XLEN)) u_abs_b (.i_din(op_b), .i_neg(w_b_neg), .o_dout(w_abs_b));

    // Shared adder: divide subtracts divisor from {rem, dividend MSB}; multiply adds multiplicand.
    assign w_add_a = r_f3[2] ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
    assign w_add_b = {1'b0, (r_f3[2] | r_acc[0]) ? r_opnd : {XLEN{1'b0}}};
    assign w_sum   = r_f3[2] ? (w_add_a - w_add_b) : (w_add_a + w_add_b);

    assign w_acc_step = r_f3[2] ?
        {(w_sum[XLEN] ? r_acc[2*XLEN-2:XLEN-1] : w_sum[XLEN-1:0]), r_acc[XLEN-2:0], ~w_sum[XLEN]} :
        {w_sum, r_acc[XLEN-1:1]};

`ifdef MDU_MUL_EARLY_OUT_EN
    logic [XLEN-1:0]       w_mask;
    logic [c_cnt_w:0]      w_shamt;
    assign w_mask     = {XLEN{1'b1}} >> r_cnt;
    assign w_shamt    = (c_cnt_w+1)'(XLEN) - {1'b0, r_cnt};
    assign w_early    = ~r_f3[2] & ((r_acc[XLEN-1:0] & w_mask) == '0);
    assign w_acc_calc = w_early ? (r_acc >> w_shamt) : w_acc_step;
`else
    assign w_early    = 1'b0;
    assign w_acc_calc = w_acc_step;
`endif

    assign w_lo      = r_acc[XLEN-1:0];
    assign w_hi      = r_acc[2*XLEN-1:XLEN];
    assign w_lo_zero = (w_lo == '0);

    // High-word negate of a 2*XLEN product: borrow from the low word only when it is zero.
    always_comb begin
        w_fix_in   = w_lo;
        w_fix_neg  = r_sign_a ^ r_sign_b;
        w_fix_ones = 1'b0;
        case (r_f3)
            F3_MULH, F3_MULHSU, F3_MULHU: begin
                w_fix_in   = w_hi;
                w_fix_neg  = (r_sign_a ^ r_sign_b) & w_lo_zero;
                w_fix_ones = (r_sign_a ^ r_sign_b) & ~w_lo_zero;
            end
            F3_REM, F3_REMU: begin
                w_fix_in  = w_hi;
                w_fix_neg = r_sign_a;
            end
            default: ;
        endcase
    end

    mdu_cond_neg #(.WIDTH(XLEN)) u_fix (.i_din(w_fix_in), .i_neg(w_fix_neg), .o_dout(w_fix_out));
    assign w_fix_val = w_fix_ones ? ~w_hi : w_fix_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && !flush) w_next = w_special ? DONE : CALC;
            CALC:    if (flush) w_next = IDLE;
                     else if ((r_cnt == c_last) || w_early) w_next = FIX;
            FIX:     w_next = flush ? IDLE : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        busy  = (r_state != IDLE);
        done  = (r_state == DONE);
        stall = (start & (r_state == IDLE)) | (busy & ~done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f3     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: if (start && !flush) begin
                    r_f3     <= funct3;
                    r_sign_a <= w_a_neg;
                    r_sign_b <= w_b_neg;
                    r_cnt    <= '0;
                    r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                    r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    if (w_special) r_result <= w_special_val;
                end
                CALC: if (!flush) begin
                    r_acc <= w_acc_calc;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                FIX:     if (!flush) r_result <= w_fix_val;
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq_ctrl.sv
// ============================================================================
// Module      : tb_mdu_seq_ctrl
// Description : Self-checking bench for mdu_seq_ctrl (directed table, corner
//               sequences and randomized ops against an arithmetic model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_seq_ctrl;
    import mdu_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, start, flush, busy, stall, done;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a, op_b, result;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mdu_seq_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .result(result)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = '0;
        case (f3)
            F3_MUL:    begin p = 64'(sa * sb); return p[31:0]; end
            F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            F3_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                q = sa / sb; return q[31:0];
            end
            F3_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            F3_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb; return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) begin
            if (b == 0) return 1;
            if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 34;
        end
`ifdef MDU_MUL_EARLY_OUT_EN
        begin
            logic [31:0] mb;
            mb = (f3 == F3_MULH && b[31]) ? (32'd0 - b) : b;
            for (int i = 0; i < 32; i++)
                if ((mb >> i) == 0) return i + 3;
        end
`endif
        return 34;
    endfunction

    // Start in cycle T, count cycles to the done pulse, then check the return to IDLE.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int          lat;
        logic        stall_ok;
        logic [31:0] got;
        @(negedge clk);
        funct3 = f3; op_a = a; op_b = b; start = 1'b1;
        #1;
        stall_ok = (stall === 1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
            @(posedge clk); #1;
        end
        got = result;
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, 64'(got), 64'(exp_res));
        check({name, " stall"}, {62'd0, stall_ok, stall}, 64'd2);
        @(posedge clk); #1;
        check({name, " idle"}, {30'd0, done, busy, result}, {32'd0, exp_res});
    endtask

    vec_t vecs[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev, ra, rb;
        logic [2:0]  rf;
        logic        saw_done;

        vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'h8000_0000, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{F3_MULH,   32'hFFFF_FFFF,  32'h8000_0000, 32'h0000_0000, 34};
        vecs[5]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vecs[6]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[7]  = '{F3_DIVU,   32'd100,        32'd7,         32'd14,        34};
        vecs[8]  = '{F3_REMU,   32'd100,        32'd7,         32'd2,         34};
        vecs[9]  = '{F3_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         34};
        vecs[10] = '{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[11] = '{F3_REM,    32'd5,          32'd0,         32'd5,         1};
        vecs[12] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[13] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", {60'd0, busy, done, stall, 1'b0}, 64'd0);
        check("reset result", 64'(result), 64'd0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        // flush and start in the same IDLE cycle: start must be ignored
        @(negedge clk);
        funct3 = F3_DIVU; op_a = 32'd9; op_b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("start+flush ignored", {62'd0, busy, done}, 64'd0);

        // flush mid-divide at T+10, then a MUL 3x4 at T+12
        prev = result;
        saw_done = 1'b0;
        @(negedge clk);
        funct3 = F3_DIV; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 10; n++) begin
            if (done === 1'b1) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("flush busy before", 64'(busy), 64'd1);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush to idle", {61'd0, saw_done, busy, done}, 64'd0);
        check("flush result held", 64'(result), 64'(prev));
        @(posedge clk);
        run_op("mul after flush", F3_MUL, 32'd3, 32'd4, 32'd12, ref_latency(F3_MUL, 32'd3, 32'd4));

        // asynchronous reset at T+20 of a MULHU
        @(negedge clk);
        funct3 = F3_MULHU; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        check("async reset busy/done", {62'd0, busy, done}, 64'd0);
        check("async reset result", 64'(result), 64'd0);
        @(negedge clk); rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("no done after reset", 64'(saw_done), 64'd0);

        run_op("mul 9x0", F3_MUL, 32'd9, 32'd0, 32'd0, ref_latency(F3_MUL, 32'd9, 32'd0));

        for (int k = 0; k < 150; k++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: ra = 32'h8000_0000;
                2: ra = 32'hFFFF_FFFF;
                3: ra = 32'($urandom_range(0, 15));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(0, 15));
                4: rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op($sformatf("rand%0d f3=%0d a=%h b=%h", k, rf, ra, rb), rf, ra, rb,
                   ref_result(rf, ra, rb), ref_latency(rf, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
